// File: rtl/serial_mem_port.sv
// serial_mem_port: byte-serial link between the CPU control FSM and the
// external memory host.
//   TX: frames a 16-bit word as header {kind,6'b0}, hi byte, lo byte.
//   RX: reassembles hi/lo bytes into a word. If too many idle cycles pass
//       between accepted bytes, the receive is abandoned.
//   The TX and RX paths are independent and may run concurrently.
// Optional build macro SERIAL_CHECKSUM_EN:
//   - TX appends a CHK byte (hdr ^ hi ^ lo).
//   - RX expects a CHK byte (hi ^ lo) and adds the rx_err output.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   tx_start/tx_word/tx_kind   send request (honoured only while !tx_busy)
//   tx_busy, tx_done      frame in progress / one-cycle completion pulse
//   ard_tx_data/valid/ready    byte channel to the host
//   rx_arm                receive request (honoured only while !rx_busy)
//   rx_busy, rx_word      receive in progress / last good word
//   rx_valid, rx_timeout  one-cycle result pulses
//   ard_rx_data/valid/ready    byte channel from the host
//   rx_err                (checksum build only) one-cycle checksum-mismatch pulse
module serial_mem_port #(
  parameter int unsigned RX_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_start,
  input  logic [15:0] tx_word,
  input  logic [1:0]  tx_kind,
  output logic        tx_busy,
  output logic        tx_done,
  output logic [7:0]  ard_tx_data,
  output logic        ard_tx_valid,
  input  logic        ard_tx_ready,
  input  logic        rx_arm,
  output logic        rx_busy,
  output logic [15:0] rx_word,
  output logic        rx_valid,
  output logic        rx_timeout,
  input  logic [7:0]  ard_rx_data,
  input  logic        ard_rx_valid,
  output logic        ard_rx_ready
`ifdef SERIAL_CHECKSUM_EN
  ,
  output logic        rx_err
`endif
);

  typedef enum logic [2:0] {
    TX_IDLE, TX_HDR, TX_HI, TX_LO
`ifdef SERIAL_CHECKSUM_EN
    , TX_CHK
`endif
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE, RX_HI, RX_LO
`ifdef SERIAL_CHECKSUM_EN
    , RX_CHK
`endif
  } rx_state_t;

  // ---------------- TX path ----------------
  tx_state_t   tx_state, tx_next;
  logic [15:0] tx_word_q;
  logic [1:0]  tx_kind_q;
  logic        tx_done_next;
  logic [7:0]  tx_hdr;

  assign tx_hdr  = {tx_kind_q, 6'b000000};
  assign tx_busy = (tx_state != TX_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state  <= TX_IDLE;
      tx_word_q <= '0;
      tx_kind_q <= '0;
      tx_done   <= 1'b0;
    end else begin
      tx_state <= tx_next;
      tx_done  <= tx_done_next;
      if (tx_state == TX_IDLE && tx_start) begin
        tx_word_q <= tx_word;
        tx_kind_q <= tx_kind;
      end
    end
  end

  always_comb begin
    tx_next      = tx_state;
    tx_done_next = 1'b0;
    ard_tx_valid = 1'b0;
    ard_tx_data  = '0;
    case (tx_state)
      TX_IDLE: if (tx_start) tx_next = TX_HDR;
      TX_HDR: begin
        ard_tx_valid = 1'b1;
        ard_tx_data  = tx_hdr;
        if (ard_tx_ready) tx_next = TX_HI;
      end
      TX_HI: begin
        ard_tx_valid = 1'b1;
        ard_tx_data  = tx_word_q[15:8];
        if (ard_tx_ready) tx_next = TX_LO;
      end
      TX_LO: begin
        ard_tx_valid = 1'b1;
        ard_tx_data  = tx_word_q[7:0];
        if (ard_tx_ready) begin
`ifdef SERIAL_CHECKSUM_EN
          tx_next = TX_CHK;
`else
          tx_next      = TX_IDLE;
          tx_done_next = 1'b1;
`endif
        end
      end
`ifdef SERIAL_CHECKSUM_EN
      TX_CHK: begin
        ard_tx_valid = 1'b1;
        ard_tx_data  = tx_hdr ^ tx_word_q[15:8] ^ tx_word_q[7:0];
        if (ard_tx_ready) begin
          tx_next      = TX_IDLE;
          tx_done_next = 1'b1;
        end
      end
`endif
      default: tx_next = TX_IDLE;
    endcase
  end

  // ---------------- RX path ----------------
  rx_state_t   rx_state, rx_next;
  logic [7:0]  rx_hi;
  logic [15:0] rx_cnt;
  logic [16:0] cnt_inc;
  logic [15:0] commit_word;
  logic        rx_accept, ld_hi, commit, to_fire, err_fire, cnt_clear;
`ifdef SERIAL_CHECKSUM_EN
  logic [7:0]  rx_lo;
  logic        ld_lo;
`endif

  assign ard_rx_ready = (rx_state != RX_IDLE);
  assign rx_busy      = ard_rx_ready;
  assign rx_accept    = ard_rx_valid && ard_rx_ready;
  assign cnt_inc      = {1'b0, rx_cnt} + 17'd1;

  always_comb begin
    rx_next     = rx_state;
    ld_hi       = 1'b0;
    commit      = 1'b0;
    commit_word = {rx_hi, ard_rx_data};
    to_fire     = 1'b0;
    err_fire    = 1'b0;
    cnt_clear   = 1'b0;
`ifdef SERIAL_CHECKSUM_EN
    ld_lo       = 1'b0;
`endif
    if (rx_state == RX_IDLE) begin
      if (rx_arm) begin
        rx_next   = RX_HI;
        cnt_clear = 1'b1;
      end
    end else if (rx_accept) begin
      // An accepted byte always wins over a timeout landing in the same cycle.
      cnt_clear = 1'b1;
      case (rx_state)
        RX_HI: begin
          ld_hi   = 1'b1;
          rx_next = RX_LO;
        end
        RX_LO: begin
`ifdef SERIAL_CHECKSUM_EN
          ld_lo   = 1'b1;
          rx_next = RX_CHK;
`else
          commit  = 1'b1;
          rx_next = RX_IDLE;
`endif
        end
`ifdef SERIAL_CHECKSUM_EN
        RX_CHK: begin
          commit_word = {rx_hi, rx_lo};
          if (ard_rx_data == (rx_hi ^ rx_lo)) commit = 1'b1;
          else err_fire = 1'b1;
          rx_next = RX_IDLE;
        end
`endif
        default: rx_next = RX_IDLE;
      endcase
    end else if (cnt_inc == 17'(RX_TIMEOUT)) begin
      to_fire   = 1'b1;
      cnt_clear = 1'b1;
      rx_next   = RX_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state   <= RX_IDLE;
      rx_hi      <= '0;
      rx_cnt     <= '0;
      rx_word    <= '0;
      rx_valid   <= 1'b0;
      rx_timeout <= 1'b0;
`ifdef SERIAL_CHECKSUM_EN
      rx_lo      <= '0;
      rx_err     <= 1'b0;
`endif
    end else begin
      rx_state   <= rx_next;
      rx_valid   <= commit;
      rx_timeout <= to_fire;
      if (cnt_clear) rx_cnt <= '0;
      else if (rx_state != RX_IDLE) rx_cnt <= cnt_inc[15:0];
      if (ld_hi) rx_hi <= ard_rx_data;
      if (commit) rx_word <= commit_word;
`ifdef SERIAL_CHECKSUM_EN
      if (ld_lo) rx_lo <= ard_rx_data;
      rx_err <= err_fire;
`endif
    end
  end

endmodule

// File: tb/tb_serial_mem_port.sv
// Scoreboard bench for serial_mem_port: stimulus pushes expected TX bytes and
// RX results into queues; a negedge monitor pops and compares them.
// Build with SERIAL_CHECKSUM_EN defined to exercise the checksum variant.
module tb_serial_mem_port;
  localparam int unsigned RX_TO = 8;
`ifdef SERIAL_CHECKSUM_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        tx_start = 1'b0;
  logic [15:0] tx_word = '0;
  logic [1:0]  tx_kind = '0;
  logic        tx_busy, tx_done;
  logic [7:0]  ard_tx_data;
  logic        ard_tx_valid;
  logic        ard_tx_ready = 1'b0;
  logic        rx_arm = 1'b0;
  logic        rx_busy;
  logic [15:0] rx_word;
  logic        rx_valid, rx_timeout;
  logic [7:0]  ard_rx_data = '0;
  logic        ard_rx_valid = 1'b0;
  logic        ard_rx_ready;
`ifdef SERIAL_CHECKSUM_EN
  logic        rx_err;
`endif

  serial_mem_port #(.RX_TIMEOUT(RX_TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_start(tx_start), .tx_word(tx_word), .tx_kind(tx_kind),
    .tx_busy(tx_busy), .tx_done(tx_done),
    .ard_tx_data(ard_tx_data), .ard_tx_valid(ard_tx_valid), .ard_tx_ready(ard_tx_ready),
    .rx_arm(rx_arm), .rx_busy(rx_busy), .rx_word(rx_word),
    .rx_valid(rx_valid), .rx_timeout(rx_timeout),
    .ard_rx_data(ard_rx_data), .ard_rx_valid(ard_rx_valid), .ard_rx_ready(ard_rx_ready)
`ifdef SERIAL_CHECKSUM_EN
    , .rx_err(rx_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  // d[8]=1 marks the tx_done pulse rather than a byte.
  typedef struct packed { logic [8:0] d; int cyc; } tx_exp_t;
  // kind: 0=rx_valid, 1=rx_timeout, 2=rx_err
  typedef struct packed { int kind; logic [15:0] w; int cyc; } rx_exp_t;
  tx_exp_t txq[$];
  rx_exp_t rxq[$];
  logic [15:0] exp_word = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  tx_exp_t    te;
  rx_exp_t    re;
  logic       hold = 1'b0;
  logic [7:0] hold_data = '0;
  int         last_acc = 0;
  logic       err_now;
  int         kind_now;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) chk("tx_hold", {ard_tx_valid, ard_tx_data}, {1'b1, hold_data});
      hold      = ard_tx_valid && !ard_tx_ready;
      hold_data = ard_tx_data;
      if (ard_tx_valid && ard_tx_ready) begin
        if (txq.size() == 0) flag("tx_extra_byte");
        else begin
          te = txq.pop_front();
          chk("tx_byte", {1'b0, ard_tx_data}, te.d);
          chk("tx_byte_cycle", cyc, te.cyc);
        end
        last_acc = cyc;
      end
      if (tx_done) begin
        chk("tx_done_busy", tx_busy, 0);
        if (txq.size() == 0) flag("tx_extra_done");
        else begin
          te = txq.pop_front();
          chk("tx_done_order", te.d, 9'h100);
          chk("tx_done_cycle", cyc, te.cyc);
          chk("tx_done_after_last", cyc, last_acc + 1);
        end
      end
`ifdef SERIAL_CHECKSUM_EN
      err_now = rx_err;
`else
      err_now = 1'b0;
`endif
      if (rx_valid || rx_timeout || err_now) begin
        chk("rx_exclusive", 32'(rx_valid) + 32'(rx_timeout) + 32'(err_now), 1);
        kind_now = rx_valid ? 0 : (rx_timeout ? 1 : 2);
        if (rxq.size() == 0) flag("rx_extra_event");
        else begin
          re = rxq.pop_front();
          chk("rx_kind", kind_now, re.kind);
          chk("rx_word", rx_word, re.w);
          chk("rx_cycle", cyc, re.cyc);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Assumes ard_tx_ready=1 for the whole frame.
  task automatic tx_kick(input logic [1:0] k, input logic [15:0] w);
    int s = cyc;
    logic [7:0] h = {k, 6'b000000};
    txq.push_back('{d: {1'b0, h},       cyc: s + 1});
    txq.push_back('{d: {1'b0, w[15:8]}, cyc: s + 2});
    txq.push_back('{d: {1'b0, w[7:0]},  cyc: s + 3});
`ifdef SERIAL_CHECKSUM_EN
    txq.push_back('{d: {1'b0, h ^ w[15:8] ^ w[7:0]}, cyc: s + 4});
`endif
    txq.push_back('{d: 9'h100, cyc: s + NB + 1});
    tx_kind  = k;
    tx_word  = w;
    tx_start = 1'b1;
    tick;
    tx_start = 1'b0;
  endtask

  task automatic wait_tx_idle;
    int n = 0;
    while (tx_busy && n < 300) begin tick; n++; end
    if (n >= 300) flag("tx_idle_wait");
    tick;
    tick;
  endtask

  task automatic wait_rx_idle;
    int n = 0;
    while (rx_busy && n < 300) begin tick; n++; end
    if (n >= 300) flag("rx_idle_wait");
    tick;
    tick;
  endtask

  task automatic arm(output int r);
    r = cyc;
    rx_arm = 1'b1;
    tick;
    rx_arm = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b, input int gap, output int acc);
    int n = 0;
    repeat (gap) tick;
    ard_rx_valid = 1'b1;
    ard_rx_data  = b;
    while (!ard_rx_ready && n < 100) begin tick; n++; end
    if (n >= 100) flag("rx_byte_wait");
    acc = cyc;
    tick;
    ard_rx_valid = 1'b0;
    ard_rx_data  = '0;
  endtask

  task automatic rx_recv(input logic [7:0] hi, input logic [7:0] lo, input int gap);
    int r, a;
    arm(r);
    rx_byte(hi, gap, a);
    rx_byte(lo, gap, a);
`ifdef SERIAL_CHECKSUM_EN
    rx_byte(hi ^ lo, 0, a);
`endif
    exp_word = {hi, lo};
    rxq.push_back('{kind: 0, w: exp_word, cyc: cyc});
    wait_rx_idle;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int r, a, s;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_tx", {tx_busy, tx_done, ard_tx_valid, ard_tx_data}, 0);
    chk("reset_rx", {rx_busy, rx_valid, rx_timeout, ard_rx_ready, rx_word}, 0);
    repeat (2) tick;
    rst_n = 1'b1;
    tick;

    // Basic send, then a second start exactly in the tx_done cycle.
    ard_tx_ready = 1'b1;
    tx_kick(2'd2, 16'hA55A);
    repeat (NB) tick;
    tx_kick(2'd1, 16'h00FF);
    wait_tx_idle;

    // Backpressure on the hi byte; tx_start during the frame must be ignored.
    s = cyc;
    txq.push_back('{d: 9'h000, cyc: s + 1});
    txq.push_back('{d: 9'h0A5, cyc: s + 5});
    txq.push_back('{d: 9'h05A, cyc: s + 6});
`ifdef SERIAL_CHECKSUM_EN
    txq.push_back('{d: 9'h0FF, cyc: s + 7});
`endif
    txq.push_back('{d: 9'h100, cyc: s + NB + 4});
    tx_kind = 2'd0; tx_word = 16'hA55A; tx_start = 1'b1;
    tick;                                   // s+1: header accepted
    tx_start = 1'b0;
    tick;                                   // s+2: in hi byte
    ard_tx_ready = 1'b0; tx_start = 1'b1; tx_word = 16'hFFFF;
    tick;
    tx_start = 1'b0;
    tick;
    tick;                                   // s+5
    ard_tx_ready = 1'b1;
    repeat (12) tick;

    // Bytes offered before rx_arm must not be consumed.
    ard_rx_valid = 1'b1; ard_rx_data = 8'h77;
    repeat (3) begin
      chk("rx_ready_idle", {ard_rx_ready, rx_busy}, 0);
      tick;
    end
    ard_rx_valid = 1'b0;
    rx_recv(8'h12, 8'h34, 2);

    // Timeout after one byte: pulse follows RX_TO idle cycles after acceptance.
    arm(r);
    rx_byte(8'hAB, 0, a);
    rxq.push_back('{kind: 1, w: exp_word, cyc: a + RX_TO + 1});
    wait_rx_idle;

    // Timeout with no byte at all.
    arm(r);
    rxq.push_back('{kind: 1, w: exp_word, cyc: r + RX_TO + 1});
    wait_rx_idle;

    // Bytes arriving on the last allowed cycle are accepted, no timeout.
    rx_recv(8'hBE, 8'hEF, RX_TO - 1);

    // Overlapped TX and RX.
    fork
      begin tx_kick(2'd3, 16'h0F0F); wait_tx_idle; end
      rx_recv(8'hC3, 8'h3C, 1);
    join

    // Asynchronous reset during the hi byte aborts the frame silently.
    tx_kick(2'd1, 16'hBEEF);
    tick;
    ard_tx_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_tx", {tx_busy, tx_done, ard_tx_valid, ard_tx_data}, 0);
    chk("async_reset_rx", {rx_busy, rx_valid, rx_timeout, ard_rx_ready, rx_word}, 0);
    txq.delete();
    exp_word = '0;
    tick;
    tick;
    rst_n = 1'b1;
    ard_tx_ready = 1'b1;
    repeat (10) tick;

`ifdef SERIAL_CHECKSUM_EN
    // Good checksum, then a bad one leaving rx_word unchanged.
    rx_recv(8'h12, 8'h34, 0);
    arm(r);
    rx_byte(8'h12, 0, a);
    rx_byte(8'h34, 0, a);
    rx_byte(8'h00, 0, a);
    rxq.push_back('{kind: 2, w: exp_word, cyc: cyc});
    wait_rx_idle;
`endif

    repeat (5) tick;
    chk("txq_drained", txq.size(), 0);
    chk("rxq_drained", rxq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
